// File: rtl/sequence_datapath.sv
// sequence_datapath: storage and counters for a colour-sequence memory game.
//
// A 16-bit Fibonacci LFSR produces a pseudo-random one-hot colour. On i_mem_wr,
// that colour is stored at o_sequence_index. On i_mem_rd, the entry at
// o_match_index is registered onto o_sequence_item, and o_item_valid pulses
// for one cycle. The two index counters and the score counter each saturate
// at their maximum value, and each has its own synchronous clear.
//
// Optional feature (macro SEQ_DP_REPEAT_GUARD_EN): if a new colour equals the
// previous entry, it is rotated left by one bit before it is written, so two
// consecutive items never match. The default build leaves the macro undefined
// and writes the raw colour.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_mem_wr                      store the generated colour at o_sequence_index
//   i_mem_rd                      read memory at o_match_index (1-cycle latency)
//   i_inc_sequence_index          sequence index increment strobe
//   i_inc_match_index             match index increment strobe
//   i_rst_sequence/_match/_score  synchronous counter clears (beat increments)
//   i_inc_score                   score increment strobe
//   i_load_seed, i_seed[15:0]     load the LFSR (a zero seed loads 16'hACE1)
//   o_sequence_item               registered read data, held between reads
//   o_sequence_index              number of stored items
//   o_match_index                 replay/compare position
//   o_score                       score counter
//   o_item_valid                  high in the cycle after i_mem_rd
module sequence_datapath #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned SCORE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_mem_wr,
  input  logic                   i_mem_rd,
  input  logic                   i_inc_sequence_index,
  input  logic                   i_inc_match_index,
  input  logic                   i_rst_sequence,
  input  logic                   i_rst_match,
  input  logic                   i_rst_score,
  input  logic                   i_inc_score,
  input  logic                   i_load_seed,
  input  logic [15:0]            i_seed,
  output logic [DATA_WIDTH-1:0]  o_sequence_item,
  output logic [ADDR_WIDTH-1:0]  o_sequence_index,
  output logic [ADDR_WIDTH-1:0]  o_match_index,
  output logic [SCORE_WIDTH-1:0] o_score,
  output logic                   o_item_valid
);

  localparam int unsigned            Depth     = 2 ** ADDR_WIDTH;
  localparam logic [15:0]            LfsrInit  = 16'hACE1;
  localparam logic [ADDR_WIDTH-1:0]  IdxMax    = '1;
  localparam logic [SCORE_WIDTH-1:0] ScoreMax  = '1;

  logic [15:0]            r_lfsr;
  logic [ADDR_WIDTH-1:0]  r_seq_idx;
  logic [ADDR_WIDTH-1:0]  r_match_idx;
  logic [SCORE_WIDTH-1:0] r_score;
  logic [DATA_WIDTH-1:0]  r_item;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_mem [Depth];

  logic                   w_lfsr_fb;
  logic [DATA_WIDTH-1:0]  w_color;
  logic [DATA_WIDTH-1:0]  w_wr_data;

  // Taps 16,14,13,11 in right-shift form: new MSB from bits 0,2,3,5.
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // One-hot decode of the two LFSR LSBs.
  assign w_color = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << r_lfsr[1:0];

`ifdef SEQ_DP_REPEAT_GUARD_EN
  logic [DATA_WIDTH-1:0] w_prev_item;
  assign w_prev_item = r_mem[r_seq_idx - ADDR_WIDTH'(1)];

  // Index 0 has no predecessor, so it is never compared.
  always_comb begin
    w_wr_data = w_color;
    if (r_seq_idx != '0 && w_color == w_prev_item) begin
      w_wr_data = {w_color[DATA_WIDTH-2:0], w_color[DATA_WIDTH-1]};
    end
  end
`else
  assign w_wr_data = w_color;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LfsrInit;
    end else if (i_load_seed) begin
      r_lfsr <= (i_seed == 16'h0000) ? LfsrInit : i_seed;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_idx   <= '0;
      r_match_idx <= '0;
      r_score     <= '0;
    end else begin
      if (i_rst_sequence) begin
        r_seq_idx <= '0;
      end else if (i_inc_sequence_index && r_seq_idx != IdxMax) begin
        r_seq_idx <= r_seq_idx + ADDR_WIDTH'(1);
      end

      if (i_rst_match) begin
        r_match_idx <= '0;
      end else if (i_inc_match_index && r_match_idx != IdxMax) begin
        r_match_idx <= r_match_idx + ADDR_WIDTH'(1);
      end

      if (i_rst_score) begin
        r_score <= '0;
      end else if (i_inc_score && r_score != ScoreMax) begin
        r_score <= r_score + SCORE_WIDTH'(1);
      end
    end
  end

  // Memory contents are not reset. The write uses the index from before the
  // increment, and a read in the same cycle sees the old entry.
  always_ff @(posedge clk) begin
    if (i_mem_wr) begin
      r_mem[r_seq_idx] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_item  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_mem_rd;
      if (i_mem_rd) begin
        r_item <= r_mem[r_match_idx];
      end
    end
  end

  assign o_sequence_item  = r_item;
  assign o_sequence_index = r_seq_idx;
  assign o_match_index    = r_match_idx;
  assign o_score          = r_score;
  assign o_item_valid     = r_valid;

endmodule

// File: tb/tb_sequence_datapath.sv
// Directed bench for sequence_datapath. A vector table covers writes, reads,
// seeding, read-before-write and counter clears. Hand-written sequences cover
// saturation, overwriting the last entry, and reset in the middle of a read.
// Expected colours come from LFSR states worked out by hand from 16'hACE1:
//   ACE1->0010, 5670->0001, AB38->0001, 559C->0001, 2ACE->0100, 1567->1000.
module tb_sequence_datapath;

  logic        clk;
  logic        rst_n;
  logic        mem_wr, mem_rd, inc_seq, inc_match;
  logic        rst_seq, rst_match, rst_score, inc_score, load_seed;
  logic [15:0] seed;
  logic [3:0]  item;
  logic [4:0]  seq_idx, match_idx;
  logic [7:0]  score;
  logic        valid;

  int n_checks = 0;
  int n_pass   = 0;

  sequence_datapath dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_mem_wr             (mem_wr),
    .i_mem_rd             (mem_rd),
    .i_inc_sequence_index (inc_seq),
    .i_inc_match_index    (inc_match),
    .i_rst_sequence       (rst_seq),
    .i_rst_match          (rst_match),
    .i_rst_score          (rst_score),
    .i_inc_score          (inc_score),
    .i_load_seed          (load_seed),
    .i_seed               (seed),
    .o_sequence_item      (item),
    .o_sequence_index     (seq_idx),
    .o_match_index        (match_idx),
    .o_score              (score),
    .o_item_valid         (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, iseq, imat, rseq, rmat, rsc, isc, ld;
    logic [15:0] sd;
    logic [3:0]  e_item;
    logic        e_valid;
    logic [4:0]  e_seq, e_match;
    logic [7:0]  e_score;
  } vec_t;

  // With the repeat guard, entry 3 (0001 after 0001) is rotated to 0010.
`ifdef SEQ_DP_REPEAT_GUARD_EN
  localparam logic [3:0] Mem3 = 4'b0010;
`else
  localparam logic [3:0] Mem3 = 4'b0001;
`endif

  function automatic vec_t mk(input logic wr, rd, iseq, imat, rseq, rmat, rsc, isc, ld,
                              input logic [15:0] sd, input logic [3:0] e_item,
                              input logic e_valid, input logic [4:0] e_seq, e_match,
                              input logic [7:0] e_score);
    vec_t v;
    v.wr = wr; v.rd = rd; v.iseq = iseq; v.imat = imat; v.rseq = rseq; v.rmat = rmat;
    v.rsc = rsc; v.isc = isc; v.ld = ld; v.sd = sd; v.e_item = e_item;
    v.e_valid = e_valid; v.e_seq = e_seq; v.e_match = e_match; v.e_score = e_score;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic idle();
    mem_wr = 0; mem_rd = 0; inc_seq = 0; inc_match = 0; rst_seq = 0; rst_match = 0;
    rst_score = 0; inc_score = 0; load_seed = 0; seed = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];

  initial begin
    //           wr rd is im rs rm rc ic ld seed     item     v  seq    match  score
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0000, 0, 5'd0, 5'd0, 8'd0);
    vecs[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0000, 0, 5'd1, 5'd0, 8'd0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0,   4'b0000, 0, 5'd1, 5'd0, 8'd0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0000, 0, 5'd2, 5'd0, 8'd0);
    vecs[4]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0000, 0, 5'd3, 5'd0, 8'd0);
    vecs[5]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0000, 0, 5'd4, 5'd0, 8'd0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0,   4'b0000, 0, 5'd4, 5'd0, 8'd0);
    vecs[7]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0,   4'b0001, 1, 5'd4, 5'd1, 8'd0);
    vecs[8]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0,   4'b0010, 1, 5'd4, 5'd2, 8'd0);
    vecs[9]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0,   4'b0001, 1, 5'd4, 5'd3, 8'd0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0,   4'b0001, 0, 5'd4, 5'd3, 8'd1);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0,   Mem3,    1, 5'd4, 5'd3, 8'd1);
    vecs[12] = mk(0, 0, 1, 1, 1, 1, 0, 1, 1, 16'h0,   Mem3,    0, 5'd0, 5'd0, 8'd2);
    vecs[13] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0001, 1, 5'd0, 5'd0, 8'd2);
    vecs[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0010, 1, 5'd0, 5'd0, 8'd2);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h1567, 4'b0010, 0, 5'd0, 5'd0, 8'd0);
    vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0,   4'b0010, 0, 5'd0, 5'd0, 8'd0);
    vecs[17] = mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0,   4'b1000, 1, 5'd0, 5'd0, 8'd1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0,   4'b1000, 0, 5'd0, 5'd0, 8'd0);

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset item", 32'(item), 32'h0);
    check("reset valid", 32'(valid), 32'h0);
    check("reset seq", 32'(seq_idx), 32'h0);
    check("reset match", 32'(match_idx), 32'h0);
    check("reset score", 32'(score), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      mem_wr = vecs[i].wr; mem_rd = vecs[i].rd; inc_seq = vecs[i].iseq;
      inc_match = vecs[i].imat; rst_seq = vecs[i].rseq; rst_match = vecs[i].rmat;
      rst_score = vecs[i].rsc; inc_score = vecs[i].isc; load_seed = vecs[i].ld;
      seed = vecs[i].sd;
      step();
      check($sformatf("v%0d item", i), 32'(item), 32'(vecs[i].e_item));
      check($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d seq", i), 32'(seq_idx), 32'(vecs[i].e_seq));
      check($sformatf("v%0d match", i), 32'(match_idx), 32'(vecs[i].e_match));
      check($sformatf("v%0d score", i), 32'(score), 32'(vecs[i].e_score));
    end

    // Index saturation, and overwriting the last entry.
    idle();
    inc_seq = 1; inc_match = 1;
    repeat (40) step();
    check("seq saturate", 32'(seq_idx), 32'd31);
    check("match saturate", 32'(match_idx), 32'd31);
    idle(); load_seed = 1; seed = 16'h0000;
    step();
    idle(); mem_wr = 1; inc_seq = 1;
    step();
    check("seq stays 31", 32'(seq_idx), 32'd31);
    idle(); mem_rd = 1; load_seed = 1; seed = 16'h1567;
    step();
    check("entry31 first", 32'(item), 32'h2);
    idle(); mem_wr = 1;
    step();
    idle(); mem_rd = 1;
    step();
    check("entry31 overwrite", 32'(item), 32'h8);
    idle(); rst_seq = 1; inc_seq = 1; rst_match = 1; inc_match = 1;
    step();
    check("rst_seq beats inc", 32'(seq_idx), 32'd0);
    check("rst_match beats inc", 32'(match_idx), 32'd0);

    // Score saturation.
    idle(); inc_score = 1;
    repeat (300) step();
    check("score saturate", 32'(score), 32'd255);
    rst_score = 1;
    step();
    check("rst_score beats inc", 32'(score), 32'd0);

    // Reset in the middle of a read, then the first cycle after release.
    idle(); inc_seq = 1; inc_match = 1; inc_score = 1;
    repeat (2) step();
    idle(); mem_rd = 1;
    #3 rst_n = 1'b0;
    #1;
    check("async rst seq", 32'(seq_idx), 32'd0);
    check("async rst match", 32'(match_idx), 32'd0);
    check("async rst score", 32'(score), 32'd0);
    step();
    check("rst kills valid", 32'(valid), 32'h0);
    check("rst item", 32'(item), 32'h0);
    #2 rst_n = 1'b1;
    idle(); mem_wr = 1; inc_seq = 1;
    step();
    check("first edge seq", 32'(seq_idx), 32'd1);
    idle(); mem_rd = 1;
    step();
    check("first edge color", 32'(item), 32'h2);
    check("first edge valid", 32'(valid), 32'h1);
    idle();
    step();
    check("valid single pulse", 32'(valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sequence_datapath.md
SEQUENCE_DATAPATH -- requirements
Module: sequence_datapath

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 4, color item width (one-hot); ADDR_WIDTH, default 5, index/memory address width; SCORE_WIDTH, default 8, score counter width.
REQ-002 Ports SHALL be, clock and reset first: clk  in  1  clock; rst_n  in  1  asynchronous, active-low reset.
REQ-003 mem_wr  in  1  generate a color and store it at sequence_index.
REQ-004 mem_rd  in  1  read memory at match_index.
REQ-005 inc_sequence_index / inc_match_index  in  1 each  counter increment strobes.
REQ-006 rst_sequence / rst_match / rst_score  in  1 each  synchronous counter clears.
REQ-007 inc_score  in  1  score increment strobe.
REQ-008 load_seed  in  1  load LFSR from seed.
REQ-009 seed  in  16  LFSR seed value.
REQ-010 sequence_item  out  DATA_WIDTH  registered memory read data.
REQ-011 sequence_index  out  ADDR_WIDTH  number of stored items.
REQ-012 match_index  out  ADDR_WIDTH  current replay/compare position.
REQ-013 score  out  SCORE_WIDTH  score counter.
REQ-014 item_valid  out  1  high the cycle after mem_rd (sequence_item updated).

Function
REQ-015 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifting every cycle load_seed is low.
REQ-016 load_seed high SHALL load seed; seed == 0 SHALL load 16'hACE1 instead (no lock-up state).
REQ-017 Generated color SHALL be the one-hot decode of lfsr[1:0] (00->0001, 01->0010, 10->0100, 11->1000).
REQ-018 The memory SHALL hold 2^ADDR_WIDTH entries of DATA_WIDTH bits, with no reset on contents.
REQ-019 mem_wr SHALL write the generated color to mem[sequence_index] using the pre-increment index value of that same cycle.
REQ-020 mem_rd SHALL register mem[match_index] into sequence_item with one-cycle latency; item_valid SHALL pulse for exactly that cycle.
REQ-021 sequence_item SHALL hold its value when mem_rd is low.
REQ-022 Simultaneous mem_wr and mem_rd to the same address SHALL return the old data (read-before-write).
REQ-023 Each index counter SHALL increment by 1 per cycle its inc strobe is high.
REQ-024 Each index counter SHALL saturate at 2^ADDR_WIDTH-1; no wrap-around.
REQ-025 Each rst_* SHALL take priority over the matching inc_* in the same cycle, clearing that counter to 0.
REQ-026 score SHALL increment on inc_score, saturate at 2^SCORE_WIDTH-1 and clear on rst_score; rst_score takes priority.
REQ-027 mem_wr at a saturated sequence_index SHALL overwrite the last entry.

Reset
REQ-028 rst_n low SHALL asynchronously force sequence_index = 0, match_index = 0, score = 0, sequence_item = 0, item_valid = 0 and lfsr = 16'hACE1.
REQ-029 Reset during a read SHALL suppress the pending item_valid pulse.
REQ-030 The first clock edge after rst_n deasserts SHALL behave as a normal cycle.

Configuration
REQ-031 With macro SEQ_DP_REPEAT_GUARD_EN defined, a generated color equal to the entry at sequence_index-1 SHALL be rotated left by one bit before it is written, so no two consecutive items match.
REQ-032 REQ-031 SHALL not apply at sequence_index 0.
REQ-033 Without SEQ_DP_REPEAT_GUARD_EN, the raw decoded color SHALL be written and the previous-entry compare logic SHALL be absent.

Verification
REQ-034 Reset, then observe without strobes: all outputs 0; after 1 cycle, lfsr has advanced from 16'hACE1.
REQ-035 load_seed with seed = 0, then mem_wr: written item equals decode of 16'hACE1 bits [1:0], i.e. 0010.
REQ-036 Three mem_wr+inc_sequence_index cycles, then rst_match, then mem_rd+inc_match_index x3: sequence_item returns entries 0,1,2 one cycle after each read, item_valid pulses 3 times, match_index = 3.
REQ-037 Assert inc_sequence_index 40 cycles: sequence_index sticks at 31; then rst_sequence together with inc_sequence_index gives 0.
REQ-038 inc_score 300 cycles: score = 255; then rst_score gives 0.
REQ-039 With SEQ_DP_REPEAT_GUARD_EN, force a seed giving the same lfsr[1:0] on two consecutive writes: entry 1 equals entry 0 rotated left (for example 0100 -> 1000).
